gpr_operand_collector: RTL and testbench

- Operand-fetch stage directly upstream of the GPR triple-port memory wrapper (1 write port, 2 read ports).
- Accepts issue requests carrying two source register indices and drives both memory read ports.
- Tracks memory read latency and forwards same-address write-backs that are in flight.
- Presents both operands, with the request tag, on a valid/ready interface to the execute stage.

---
 rtl/gpr_operand_collector_pkg.sv | 52 +++++
 rtl/gpr_operand_collector_rsp_fifo.sv | 60 ++++++
 rtl/gpr_operand_collector.sv | 130 +++++++++++++
 tb/tb_gpr_operand_collector.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpr_operand_collector_pkg.sv
// Shared types and latency helpers for the GPR operand collector.
// Record widths are fixed by the OPC_* constants below.
package e_gpu_opc_pkg;

  localparam int OPC_DATAW    = 32;
  localparam int OPC_NUM_REGS = 64;
  localparam int OPC_TAGW     = 8;
  localparam int OPC_ADDRW    = $clog2(OPC_NUM_REGS);

  typedef struct packed {
    logic [OPC_TAGW-1:0]  tag;
    logic [OPC_ADDRW-1:0] rs1;
    logic [OPC_ADDRW-1:0] rs2;
    logic                 byp1_flag;
    logic [OPC_DATAW-1:0] byp1_data;
    logic                 byp2_flag;
    logic [OPC_DATAW-1:0] byp2_data;
  } opc_entry_t;

  typedef struct packed {
    logic [OPC_TAGW-1:0]  tag;
    logic [OPC_DATAW-1:0] op1;
    logic [OPC_DATAW-1:0] op2;
  } rsp_t;

  function automatic int opc_lat(input int mem_out_reg);
    return 1 + mem_out_reg;
  endfunction

  function automatic int opc_obuf_depth(input int mem_out_reg);
    return opc_lat(mem_out_reg) + 2;
  endfunction

  // Youngest matching write-back wins; index 0 is never captured when zero_en is set.
  function automatic opc_entry_t opc_snoop(input opc_entry_t e, input logic wv,
                                           input logic [OPC_ADDRW-1:0] wa,
                                           input logic [OPC_DATAW-1:0] wd,
                                           input logic zero_en);
    opc_entry_t r;
    r = e;
    if (wv && (wa == e.rs1) && !(zero_en && (e.rs1 == {OPC_ADDRW{1'b0}}))) begin
      r.byp1_flag = 1'b1;
      r.byp1_data = wd;
    end
    if (wv && (wa == e.rs2) && !(zero_en && (e.rs2 == {OPC_ADDRW{1'b0}}))) begin
      r.byp2_flag = 1'b1;
      r.byp2_data = wd;
    end
    return r;
  endfunction

endpackage

// File: rtl/gpr_operand_collector_rsp_fifo.sv
// Response FIFO of rsp_t with flop-based head; pointers carry an extra wrap bit
// so a non-power-of-two depth still distinguishes full from empty.
module opc_rsp_fifo
  import e_gpu_opc_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  rsp_t push_data,
  input  logic pop,
  output logic valid,
  output rsp_t head
);

  localparam int PW = $clog2(DEPTH);

  rsp_t         store [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         empty;
  logic         full;
  logic         do_push;
  logic         do_pop;

  function automatic logic [PW:0] ptr_inc(input logic [PW:0] p);
    if (p[PW-1:0] == PW'(DEPTH - 1)) begin
      return {~p[PW], {PW{1'b0}}};
    end else begin
      return {p[PW], p[PW-1:0] + PW'(1)};
    end
  endfunction

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign valid   = !empty;
  assign head    = store[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        store[i] <= '0;
      end
    end else begin
      if (do_push) begin
        store[wr_ptr[PW-1:0]] <= push_data;
        wr_ptr                <= ptr_inc(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
    end
  end

endmodule

// File: rtl/gpr_operand_collector.sv
// Operand collector in front of the 1W/2R GPR memory: read-latency tracking,
// in-flight write-back forwarding, credit-limited response FIFO. Option: OPC_ZERO_REG_EN.
module gpr_operand_collector
  import e_gpu_opc_pkg::*;
#(
  parameter int DATAW       = OPC_DATAW,
  parameter int NUM_REGS    = OPC_NUM_REGS,
  parameter int MEM_OUT_REG = 0,
  parameter int TAGW        = OPC_TAGW,
  localparam int ADDRW      = $clog2(NUM_REGS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [TAGW-1:0]  req_tag_i,
  input  logic [ADDRW-1:0] req_rs1_i,
  input  logic [ADDRW-1:0] req_rs2_i,
  output logic [ADDRW-1:0] mem_raddr_1_o,
  input  logic [DATAW-1:0] mem_rdata_1_i,
  output logic [ADDRW-1:0] mem_raddr_2_o,
  input  logic [DATAW-1:0] mem_rdata_2_i,
  input  logic             wb_valid_i,
  input  logic [ADDRW-1:0] wb_addr_i,
  input  logic [DATAW-1:0] wb_data_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [TAGW-1:0]  rsp_tag_o,
  output logic [DATAW-1:0] rsp_rs1_data_o,
  output logic [DATAW-1:0] rsp_rs2_data_o
);

  localparam int L          = opc_lat(MEM_OUT_REG);
  localparam int OBUF_DEPTH = opc_obuf_depth(MEM_OUT_REG);
  localparam int CNTW       = $clog2(OBUF_DEPTH + 1);
`ifdef OPC_ZERO_REG_EN
  localparam logic ZERO_EN = 1'b1;
`else
  localparam logic ZERO_EN = 1'b0;
`endif

  logic [CNTW-1:0] cnt;
  logic            accept;
  logic            pop;
  logic            pipe_valid [L];
  opc_entry_t      pipe_q     [L];
  opc_entry_t      snooped    [L];
  opc_entry_t      new_entry;
  rsp_t            out_rsp;
  rsp_t            head;

  // Credits cover both in-flight and buffered entries, so the FIFO cannot overflow.
  assign req_ready_o   = (cnt < CNTW'(OBUF_DEPTH));
  assign accept        = req_valid_i && req_ready_o;
  assign pop           = rsp_valid_o && rsp_ready_i;
  assign mem_raddr_1_o = req_rs1_i;
  assign mem_raddr_2_o = req_rs2_i;

  always_comb begin
    new_entry     = '0;
    new_entry.tag = req_tag_i;
    new_entry.rs1 = req_rs1_i;
    new_entry.rs2 = req_rs2_i;
    new_entry     = opc_snoop(new_entry, wb_valid_i, wb_addr_i, wb_data_i, ZERO_EN);
    for (int i = 0; i < L; i++) begin
      snooped[i] = opc_snoop(pipe_q[i], wb_valid_i, wb_addr_i, wb_data_i, ZERO_EN);
    end
  end

  // Memory returns old data on read-during-write, so the last stage still snoops.
  always_comb begin
    out_rsp     = '0;
    out_rsp.tag = snooped[L-1].tag;
    if (ZERO_EN && (snooped[L-1].rs1 == '0)) begin
      out_rsp.op1 = '0;
    end else if (snooped[L-1].byp1_flag) begin
      out_rsp.op1 = snooped[L-1].byp1_data;
    end else begin
      out_rsp.op1 = mem_rdata_1_i;
    end
    if (ZERO_EN && (snooped[L-1].rs2 == '0)) begin
      out_rsp.op2 = '0;
    end else if (snooped[L-1].byp2_flag) begin
      out_rsp.op2 = snooped[L-1].byp2_data;
    end else begin
      out_rsp.op2 = mem_rdata_2_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
      for (int i = 0; i < L; i++) begin
        pipe_valid[i] <= 1'b0;
        pipe_q[i]     <= '0;
      end
    end else begin
      pipe_valid[0] <= accept;
      pipe_q[0]     <= new_entry;
      for (int i = 1; i < L; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_q[i]     <= snooped[i-1];
      end
      if (accept && !pop) begin
        cnt <= cnt + CNTW'(1);
      end else if (!accept && pop) begin
        cnt <= cnt - CNTW'(1);
      end else begin
        cnt <= cnt;
      end
    end
  end

  opc_rsp_fifo #(
    .DEPTH (OBUF_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (pipe_valid[L-1]),
    .push_data (out_rsp),
    .pop       (pop),
    .valid     (rsp_valid_o),
    .head      (head)
  );

  assign rsp_tag_o      = head.tag;
  assign rsp_rs1_data_o = head.op1;
  assign rsp_rs2_data_o = head.op2;

endmodule

// File: tb/tb_gpr_operand_collector.sv
// Directed bench: one collector with MEM_OUT_REG=0 and one with MEM_OUT_REG=1,
// each in front of its own behavioural read-old-data GPR memory.
module tb_gpr_operand_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_a, req_valid_b;
  logic [7:0]  req_tag;
  logic [5:0]  req_rs1, req_rs2;
  logic        wb_valid_a, wb_valid_b;
  logic [5:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rsp_ready;

  logic        req_ready_a, rsp_valid_a;
  logic [5:0]  raddr_a1, raddr_a2;
  logic [31:0] rdata_a1, rdata_a2;
  logic [7:0]  rsp_tag_a;
  logic [31:0] op1_a, op2_a;

  logic        req_ready_b, rsp_valid_b;
  logic [5:0]  raddr_b1, raddr_b2;
  logic [31:0] rdata_b1, rdata_b2, rdq_b1, rdq_b2;
  logic [7:0]  rsp_tag_b;
  logic [31:0] op1_b, op2_b;

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gpr_operand_collector #(.MEM_OUT_REG(0)) u_a (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid_a), .req_ready_o(req_ready_a),
    .req_tag_i(req_tag), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
    .mem_raddr_1_o(raddr_a1), .mem_rdata_1_i(rdata_a1),
    .mem_raddr_2_o(raddr_a2), .mem_rdata_2_i(rdata_a2),
    .wb_valid_i(wb_valid_a), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready), .rsp_tag_o(rsp_tag_a),
    .rsp_rs1_data_o(op1_a), .rsp_rs2_data_o(op2_a)
  );

  gpr_operand_collector #(.MEM_OUT_REG(1)) u_b (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid_b), .req_ready_o(req_ready_b),
    .req_tag_i(req_tag), .req_rs1_i(req_rs1), .req_rs2_i(req_rs2),
    .mem_raddr_1_o(raddr_b1), .mem_rdata_1_i(rdata_b1),
    .mem_raddr_2_o(raddr_b2), .mem_rdata_2_i(rdata_b2),
    .wb_valid_i(wb_valid_b), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready), .rsp_tag_o(rsp_tag_b),
    .rsp_rs1_data_o(op1_b), .rsp_rs2_data_o(op2_b)
  );

  function automatic logic [31:0] init_val(input int k);
    case (k)
      0:       return 32'h0000_DEAD;
      5:       return 32'hAAAA_0005;
      7:       return 32'h7777_7777;
      9:       return 32'h0000_0009;
      default: return 32'(k);
    endcase
  endfunction

  // Latency-1 memory: reads sample the array before this edge's write lands.
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 64; k++) mem_a[k] <= init_val(k);
      rdata_a1 <= '0;
      rdata_a2 <= '0;
    end else begin
      if (wb_valid_a) mem_a[wb_addr] <= wb_data;
      rdata_a1 <= mem_a[raddr_a1];
      rdata_a2 <= mem_a[raddr_a2];
    end
  end

  // Latency-2 memory (output register).
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 64; k++) mem_b[k] <= init_val(k);
      rdq_b1 <= '0; rdq_b2 <= '0; rdata_b1 <= '0; rdata_b2 <= '0;
    end else begin
      if (wb_valid_b) mem_b[wb_addr] <= wb_data;
      rdq_b1   <= mem_b[raddr_b1];
      rdq_b2   <= mem_b[raddr_b2];
      rdata_b1 <= rdq_b1;
      rdata_b2 <= rdq_b2;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $fatal(1, "FAIL watchdog: simulation did not finish");
  end

  initial begin
    logic [7:0] next_tag;
    int         n_acc;
    logic [31:0] zero_exp;

    rst = 1'b1; req_valid_a = 1'b0; req_valid_b = 1'b0; req_tag = 8'h00;
    req_rs1 = 6'd0; req_rs2 = 6'd0; wb_valid_a = 1'b0; wb_valid_b = 1'b0;
    wb_addr = 6'd0; wb_data = 32'h0; rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_rsp_valid", rsp_valid_a, 1'b0);
    chk("rst_req_ready", req_ready_a, 1'b1);
    chk("rst_tag", rsp_tag_a, 8'h00);
    chk("rst_op1", op1_a, 32'h0);
    chk("rst_op2", op2_a, 32'h0);
    chk("rst_raddr1", raddr_a1, 6'd0);
    chk("rst_b_ready", req_ready_b, 1'b1);

    // Plain read, latency 2 cycles.
    req_valid_a = 1'b1; req_tag = 8'h11; req_rs1 = 6'd5; req_rs2 = 6'd9;
    #1;
    chk("raddr1", raddr_a1, 6'd5);
    chk("raddr2", raddr_a2, 6'd9);
    tick();
    req_valid_a = 1'b0;
    chk("t1_early", rsp_valid_a, 1'b0);
    tick();
    chk("t1_valid", rsp_valid_a, 1'b1);
    chk("t1_tag", rsp_tag_a, 8'h11);
    chk("t1_op1", op1_a, 32'hAAAA_0005);
    chk("t1_op2", op2_a, 32'h0000_0009);
    tick();
    chk("t1_popped", rsp_valid_a, 1'b0);

    // Latency-2 instance: write one cycle after accept.
    req_valid_b = 1'b1; req_tag = 8'h33; req_rs1 = 6'd5; req_rs2 = 6'd9;
    tick();
    req_valid_b = 1'b0; wb_valid_b = 1'b1; wb_addr = 6'd5; wb_data = 32'h0000_1234;
    tick();
    wb_valid_b = 1'b0;
    chk("l2_early", rsp_valid_b, 1'b0);
    tick();
    chk("l2_valid", rsp_valid_b, 1'b1);
    chk("l2_tag", rsp_tag_b, 8'h33);
    chk("l2_op1", op1_b, 32'h0000_1234);
    chk("l2_op2", op2_b, 32'h0000_0009);
    tick();

    // Write in the accept cycle.
    req_valid_a = 1'b1; req_tag = 8'h22; req_rs1 = 6'd5; req_rs2 = 6'd9;
    wb_valid_a = 1'b1; wb_addr = 6'd5; wb_data = 32'h0000_1234;
    tick();
    req_valid_a = 1'b0; wb_valid_a = 1'b0;
    tick();
    chk("t2_tag", rsp_tag_a, 8'h22);
    chk("t2_op1", op1_a, 32'h0000_1234);
    chk("t2_op2", op2_a, 32'h0000_0009);
    tick();

    // Two writes to reg 7, youngest wins on both ports.
    req_valid_a = 1'b1; req_tag = 8'h44; req_rs1 = 6'd7; req_rs2 = 6'd7;
    wb_valid_a = 1'b1; wb_addr = 6'd7; wb_data = 32'h1;
    tick();
    req_valid_a = 1'b0; wb_data = 32'h2;
    tick();
    wb_valid_a = 1'b0;
    chk("t3_tag", rsp_tag_a, 8'h44);
    chk("t3_op1", op1_a, 32'h2);
    chk("t3_op2", op2_a, 32'h2);
    tick();

    // Register 0 behaviour.
`ifdef OPC_ZERO_REG_EN
    zero_exp = 32'h0;
`else
    zero_exp = 32'h55;
`endif
    req_valid_a = 1'b1; req_tag = 8'h66; req_rs1 = 6'd0; req_rs2 = 6'd9;
    tick();
    req_valid_a = 1'b0; wb_valid_a = 1'b1; wb_addr = 6'd0; wb_data = 32'h55;
    tick();
    wb_valid_a = 1'b0;
    chk("zero_op1", op1_a, zero_exp);
    chk("zero_op2", op2_a, 32'h9);
    tick();

    // Backpressure: three credits, then stall.
    rsp_ready = 1'b0; req_valid_a = 1'b1; req_rs1 = 6'd1; req_rs2 = 6'd2;
    next_tag = 8'h50; n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      req_tag = next_tag;
      chk("bp_ready", req_ready_a, (i < 3) ? 1'b1 : 1'b0);
      if (req_ready_a) begin
        next_tag = next_tag + 8'h01;
        n_acc++;
      end
      tick();
    end
    req_valid_a = 1'b0;
    chk("bp_accepts", 64'(n_acc), 64'd3);
    chk("bp_hold_valid", rsp_valid_a, 1'b1);
    chk("bp_hold_tag", rsp_tag_a, 8'h50);
    tick();
    chk("bp_stable_tag", rsp_tag_a, 8'h50);
    rsp_ready = 1'b1;
    tick();
    chk("bp_drain1", rsp_tag_a, 8'h51);
    tick();
    chk("bp_drain2", rsp_tag_a, 8'h52);
    tick();
    chk("bp_empty", rsp_valid_a, 1'b0);
    chk("bp_ready_back", req_ready_a, 1'b1);

    // 100 back-to-back requests.
    for (int i = 0; i < 102; i++) begin
      if (i >= 2) begin
        chk("burst_valid", rsp_valid_a, 1'b1);
        chk("burst_tag", rsp_tag_a, 8'(i - 2));
      end else begin
        chk("burst_idle", rsp_valid_a, 1'b0);
      end
      chk("burst_ready", req_ready_a, 1'b1);
      req_valid_a = (i < 100);
      req_tag = 8'(i); req_rs1 = 6'(i); req_rs2 = 6'(i + 1);
      tick();
    end
    chk("burst_done", rsp_valid_a, 1'b0);

    // Reset with two entries in flight.
    req_valid_a = 1'b1; req_tag = 8'hA0;
    tick();
    req_tag = 8'hA1;
    tick();
    req_valid_a = 1'b0;
    chk("pre_rst_valid", rsp_valid_a, 1'b1);
    chk("pre_rst_tag", rsp_tag_a, 8'hA0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("post_rst_valid", rsp_valid_a, 1'b0);
    chk("post_rst_ready", req_ready_a, 1'b1);
    chk("post_rst_tag", rsp_tag_a, 8'h00);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_quiet", rsp_valid_a, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
